// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Runs one four-operation sequence against an external registered
//   calculator. It issues ops 00..11 on four consecutive cycles and tracks
//   them through a LATENCY-deep tag pipeline. Each returned result is
//   buffered by opcode and checked against a locally computed expected
//   value. The buffered results are then handed out one at a time over a
//   valid/ready port.
//
// Parameters
//   LATENCY     cycles from calc_op/calc_a/calc_b drive to valid calc_result (1..4)
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle run request (honoured only in IDLE)
//   a_in, b_in  operands, sampled on an accepted start
//   calc_a/b    operands driven to the calculator
//   calc_op     opcode to calculator: 00 add, 01 sub, 10 or, 11 neq
//   calc_result registered calculator result
//   res_valid   res_op/res_data hold a buffered result
//   res_ready   consumer accepts the presented result
//   res_op      opcode of presented result
//   res_data    presented result
//   busy        high outside IDLE
//   done        one-cycle pulse after the last result is accepted
//   err         sticky result-mismatch flag for the current/last run
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | driving opcodes 0..3, one per cycle
// DRAIN | waiting for the last results to come back
// OUT   | presenting buffered results 0..3 over valid/ready
module calc_sequencer #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic [3:0] calc_a,
  output logic [3:0] calc_b,
  output logic [1:0] calc_op,
  input  logic [3:0] calc_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_op,
  output logic [3:0] res_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic [LATENCY-1:0] tag_v;
  logic [1:0]   tag_op [LATENCY];
  logic [3:0]   buf_data [4];
  logic [3:0]   buf_v;
  logic         cap;
  logic [1:0]   cap_op;
  logic [3:0]   cap_mask;
  logic         accept;
  logic         handshake;

  function automatic logic [3:0] exp_val(input logic [1:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
    logic [3:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a | b;
      default: r = {3'b000, (a != b)};
    endcase
    return r;
  endfunction

  // A tag leaving the last pipeline stage lines up with its calc_result.
  assign cap       = tag_v[LATENCY-1];
  assign cap_op    = tag_op[LATENCY-1];
  assign cap_mask  = cap ? (4'b0001 << cap_op) : 4'b0000;
  assign accept    = (state == IDLE) && start;
  assign handshake = (state == OUT) && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    calc_op   = 2'b00;
    res_valid = 1'b0;
    res_op    = 2'b00;
    res_data  = 4'h0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        calc_op = cnt;
        if (cnt == 2'd3) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as soon as the final capture is in flight this cycle, so OUT
        // starts on the cycle after the last buffer write.
        if (&(buf_v | cap_mask)) state_nxt = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        res_op    = cnt;
        res_data  = buf_data[cnt];
        if (res_ready && cnt == 2'd3) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      calc_a <= 4'h0;
      calc_b <= 4'h0;
      tag_v  <= '0;
      for (int i = 0; i < LATENCY; i++) tag_op[i] <= 2'd0;
      for (int i = 0; i < 4; i++) buf_data[i] <= 4'h0;
      buf_v  <= 4'h0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        calc_a <= a_in;
        calc_b <= b_in;
        cnt    <= 2'd0;
        err    <= 1'b0;
        buf_v  <= 4'h0;
      end else if (state == ISSUE || handshake) begin
        cnt <= cnt + 2'd1;
      end

      tag_v[0]  <= (state == ISSUE);
      tag_op[0] <= cnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_op[i] <= tag_op[i-1];
      end

      if (cap) begin
        buf_data[cap_op] <= calc_result;
        buf_v[cap_op]    <= 1'b1;
        if (calc_result != exp_val(cap_op, calc_a, calc_b)) err <= 1'b1;
      end

      done <= handshake && (cnt == 2'd3);
    end
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from calc_op/calc_a/calc_b drive to a valid calc_result; legal range 1..4.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to run a sequence.
REQ-005 SHALL have port a_in  input  4  operand A, sampled on accepted start.
REQ-006 SHALL have port b_in  input  4  operand B, sampled on accepted start.
REQ-007 SHALL have port calc_a  output  4  operand A driven to the calculator.
REQ-008 SHALL have port calc_b  output  4  operand B driven to the calculator.
REQ-009 SHALL have port calc_op  output  2  opcode driven to the calculator: 00 add, 01 sub, 10 or, 11 neq.
REQ-010 SHALL have port calc_result  input  4  registered calculator result.
REQ-011 SHALL have port res_valid  output  1  res_data/res_op hold a buffered result.
REQ-012 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port res_op  output  2  opcode of the presented result.
REQ-014 SHALL have port res_data  output  4  presented result.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last result is accepted.
REQ-017 SHALL have port err  output  1  sticky mismatch flag for the current/last run.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, OUT.
REQ-019 IDLE: start=1 SHALL latch a_in/b_in into calc_a/calc_b, clear err, clear the 4-entry buffer valid bits, go to ISSUE; start outside IDLE SHALL be ignored.
REQ-020 ISSUE: SHALL drive calc_op 00,01,10,11 on four consecutive cycles via a 2-bit counter, then go to DRAIN; calc_op SHALL be 00 in all other states.
REQ-021 Each issued op SHALL enter a LATENCY-deep tag pipeline (valid + opcode); when a tag emerges, calc_result SHALL be written to buffer[opcode].
REQ-022 DRAIN: SHALL wait until all four buffer entries are written, then go to OUT on the following cycle.
REQ-023 Each capture SHALL compare calc_result against the internal expected value from calc_a/calc_b; any mismatch SHALL set err, held until next accepted start or reset.
REQ-024 Expected values SHALL be 4-bit, wrap modulo 16: add a+b; sub a-b; or a|b; neq 0 if a==b else 1.
REQ-025 OUT: SHALL present buffer entries in order op 0..3 with res_valid=1, res_op=index, res_data=buffer[index].
REQ-026 Handshake completes on a cycle with res_valid&&res_ready; res_op/res_data SHALL stay stable while res_valid&&!res_ready; next entry appears the cycle after completion, no bubble.
REQ-027 On completion of entry 3, SHALL go to IDLE and assert done for exactly that next cycle; res_valid SHALL be 0 in IDLE.
REQ-028 With res_ready held 1, a full run SHALL take 1 (start) + 4 ISSUE + LATENCY DRAIN + 4 OUT cycles; done appears LATENCY+9 cycles after start.
REQ-029 res_ready SHALL be ignored when res_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE; calc_a, calc_b, calc_op, res_op, res_data=0; res_valid, busy, done, err=0; tag pipeline and buffer valid bits cleared.
REQ-031 Reset asserted mid-ISSUE, DRAIN or OUT SHALL abort the run with no done pulse; first start after release SHALL begin a clean run.

Verification
REQ-032 LATENCY=1, model calculator, res_ready=1, start a=3,b=5 -> res_data 8,14,7,1 with res_op 0,1,2,3 on consecutive cycles, done 10 cycles after start, err=0.
REQ-033 start a=9,b=9 -> res_data 2,0,9,0; err=0.
REQ-034 res_ready=0 for 3 cycles while entry 1 presented (a=3,b=5) -> res_op=1, res_data=14 held stable, then 7 and 1 follow.
REQ-035 Faulty model returns 0 for op 10 (a=3,b=5) -> err=1 after that capture, still 1 after done, cleared by next start.
REQ-036 start pulsed during ISSUE with different a_in -> ignored, results unchanged; rst_n low during OUT -> all outputs 0, no done, IDLE.
REQ-037 LATENCY=3, a=15,b=1 -> res_data 0,14,15,1; done 12 cycles after start.
